pd_stream: RTL and testbench
============================

# pd_stream

Parametrised serial pattern detector for the word-memory pattern-detection path. It reads a length word from the top memory address, then walks addresses 0..length and extracts one bit per word. Each time the last PW bits equal a programmable pattern, it pulses `flag`. Overlapping and non-overlapping match modes are supported, an optional match counter is included, and `fin` is raised when the scan is done.

## Interface
Parameters:
- `DW`, 10: memory data word width.
- `AW`, 10: address width; length word sits at address 2^AW-1.
- `PW`, 7: pattern length in bits, 1 ≤ PW ≤ 16.
- `BIT_SEL`, 0: index of the data bit examined per word.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data` in DW: word at `addr`; combinational memory read, valid in the same cycle.
- `pattern` in PW: target sequence. `pattern[PW-1]` is the oldest (first-seen) bit.
- `ovl` in 1: 1 = overlapping matches, 0 = non-overlapping.
- `addr` out AW: current memory address.
- `flag` out 1: match pulse (Mealy).
- `fin` out 1: scan complete.
- `match_cnt` out AW: number of matches, saturating.

## Operation
- States, held in a 2-bit register: INIT, SCAN, FINI.
- Reset values:
  - state = INIT
  - `addr` = all ones
  - `length` = 0, history = 0, fill = 0
  - `match_cnt` = 0, `flag` = 0, `fin` = 0
- INIT (one cycle):
  - Latch `length` = `data[AW-1:0]`, zero-extended if DW < AW.
  - Latch `pattern` and `ovl`. Changes to these inputs after INIT are ignored until the next reset.
  - Next `addr` = 0.
  - If the latched length equals all ones, next state is FINI. Otherwise next state is SCAN.
- SCAN, each cycle:
  - `b` = `data[BIT_SEL]`; `cand` = {`hist[PW-2:0]`, `b`}.
  - `hit` = (`fill` ≥ PW-1) and (`cand` == latched pattern). For PW = 1, `hit` = (`b` == `pattern[0]`).
  - `flag` = `hit`, combinational in that cycle.
  - On the clock edge: `hist` ← `cand`.
  - If `hit` and `ovl` = 0: `fill` ← 0. Otherwise `fill` ← min(`fill`+1, PW-1).
  - If `addr` == `length`: state ← FINI and `addr` holds. Otherwise `addr` ← `addr`+1.
  - The word at `addr` == `length` is still evaluated and can flag.
- FINI:
  - Sticky until reset. `fin` = 1, `flag` = 0.
  - `addr`, `match_cnt` and `hist` are frozen.
- `flag` is 0 in INIT and FINI.
- `fin` is decoded directly from state == FINI; it is a clean output with no combinational path from `data`.
- Reset mid-operation: everything returns immediately to the reset values, and the scan restarts from INIT on the next edge.

## Timing
- `flag` is valid in the same cycle that `data` at `addr` is presented; there are zero cycles of latency.
- `match_cnt` updates on the edge that ends the `flag` cycle.
- After reset release:
  - Edge 1 is INIT → SCAN at address 0.
  - The scan covers length+1 words.
  - `fin` rises after edge length+2.
  - For an all-ones length word, `fin` rises after edge 1 with `addr` = 0.
- Address arithmetic is modulo 2^AW. Wrap-around cannot occur, because `length` < 2^AW-1 whenever SCAN is entered.

## Configuration
- Macro `PD_MATCH_CNT_EN`.
- Defined: `match_cnt` counts `hit` cycles during SCAN and saturates at all ones.
- Undefined: the counter logic is removed and `match_cnt` is tied to 0. The port list is unchanged.

## Structure
- Shared package `pd_pkg` contains:
  - State enum (INIT = 2'b00, SCAN = 2'b01, FINI = 2'b11).
  - Default parameter constants.
- Sub-module `pd_dff`: parametrised-width register with asynchronous active-low reset and a reset-value input. It is used for the state, `addr`, `length`, history, fill and counter registers.

## Test plan
Concrete stimulus for every scenario:
- PW = 4, pattern 4'b1010, `ovl` = 1, length 6, bits at addresses 0..6 = 1,0,1,0,1,0,0
  - `flag` high at `addr` 3 and at `addr` 5.
  - `match_cnt` = 2; `fin` after edge 8.
- Same stimulus with `ovl` = 0
  - `flag` only at `addr` 3.
  - `match_cnt` = 1.
- Length word = 10'h3FF
  - `fin` = 1 after edge 1.
  - `flag` never asserts; `addr` = 0; `match_cnt` = 0.
- Length 0, PW = 4
  - One word scanned; no `flag`.
  - `fin` after edge 2; `addr` stays 0.
- Reset asserted at `addr` 3 during SCAN
  - `addr` = 10'h3FF, `fin` = 0, `match_cnt` = 0 immediately.
  - After release, the full scan repeats with identical results.
- `pattern` changed from 4'b1010 to 4'b0000 at `addr` 2 during SCAN
  - Matches follow the pattern latched in INIT, 4'b1010.

Source files
------------

// File: rtl/pd_pkg.sv
// Shared definitions for the pd_stream pattern detector: FSM encoding and
// default parameter values.
package pd_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_SCAN = 2'b01,
        ST_FINI = 2'b11
    } pd_state_e;

    localparam int DEF_DW      = 10;
    localparam int DEF_AW      = 10;
    localparam int DEF_PW      = 7;
    localparam int DEF_BIT_SEL = 0;

endpackage

// File: rtl/pd_dff.sv
// Parametrised-width register with enable, asynchronous active-low reset and
// a per-instance reset value.
module pd_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pd_stream.sv
// Serial pattern detector over a word memory: reads the length word at the top
// address, scans words 0..length and pulses flag on each pattern match.
// Optional saturating match counter enabled by defining PD_MATCH_CNT_EN.
module pd_stream
    import pd_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int PW      = DEF_PW,
    parameter int BIT_SEL = DEF_BIT_SEL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data,
    input  logic [PW-1:0] pattern,
    input  logic          ovl,
    output logic [AW-1:0] addr,
    output logic          flag,
    output logic          fin,
    output logic [AW-1:0] match_cnt
);

    localparam logic [1:0] S_INIT   = ST_INIT;
    localparam logic [1:0] S_SCAN   = ST_SCAN;
    localparam logic [1:0] S_FINI   = ST_FINI;
    localparam logic [4:0] FILL_MAX = 5'(PW - 1);

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [AW-1:0] len_reg, len_in;
    logic [PW-1:0] pat_reg;
    logic          ovl_reg;
    logic [PW-1:0] hist_reg, cand;
    logic [4:0]    fill_reg, fill_next;
    logic          is_init, is_scan, b, hit;
    logic          unused_data;

    assign is_init     = (state_reg == S_INIT);
    assign is_scan     = (state_reg == S_SCAN);
    assign b           = data[BIT_SEL];
    assign unused_data = ^data;

    // Length word is zero-extended when the data word is narrower than addr.
    for (genvar gi = 0; gi < AW; gi++) begin : g_len
        if (gi < DW) begin : g_bit
            assign len_in[gi] = data[gi];
        end else begin : g_pad
            assign len_in[gi] = 1'b0;
        end
    end

    if (PW == 1) begin : g_pw1
        assign cand = b;
    end else begin : g_pwn
        assign cand = {hist_reg[PW-2:0], b};
    end

    assign hit       = (fill_reg >= FILL_MAX) && (cand == pat_reg);
    assign flag      = is_scan && hit;
    assign fin       = (state_reg == S_FINI);
    assign addr      = addr_reg;
    assign fill_next = (hit && !ovl_reg) ? 5'd0 :
                       (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 5'd1;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        case (state_reg)
            S_INIT: begin
                addr_next  = '0;
                state_next = (&len_in) ? S_FINI : S_SCAN;
            end
            S_SCAN: begin
                if (addr_reg == len_reg) begin
                    state_next = S_FINI;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            S_FINI: begin
                state_next = S_FINI;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    pd_dff #(.W(2)) u_state (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .rst_val(S_INIT),
        .d(state_next), .q(state_reg)
    );

    pd_dff #(.W(AW)) u_addr (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .rst_val({AW{1'b1}}),
        .d(addr_next), .q(addr_reg)
    );

    // Length, pattern and mode are captured once in INIT and then held.
    pd_dff #(.W(AW)) u_len (
        .clk(clk), .rst_n(rst_n), .en(is_init), .rst_val({AW{1'b0}}),
        .d(len_in), .q(len_reg)
    );

    pd_dff #(.W(PW + 1)) u_cfg (
        .clk(clk), .rst_n(rst_n), .en(is_init), .rst_val({(PW + 1){1'b0}}),
        .d({pattern, ovl}), .q({pat_reg, ovl_reg})
    );

    pd_dff #(.W(PW)) u_hist (
        .clk(clk), .rst_n(rst_n), .en(is_scan), .rst_val({PW{1'b0}}),
        .d(cand), .q(hist_reg)
    );

    pd_dff #(.W(5)) u_fill (
        .clk(clk), .rst_n(rst_n), .en(is_scan), .rst_val(5'd0),
        .d(fill_next), .q(fill_reg)
    );

`ifdef PD_MATCH_CNT_EN
    logic [AW-1:0] cnt_reg;
    logic          cnt_en;

    assign cnt_en = flag && !(&cnt_reg);

    pd_dff #(.W(AW)) u_cnt (
        .clk(clk), .rst_n(rst_n), .en(cnt_en), .rst_val({AW{1'b0}}),
        .d(cnt_reg + 1'b1), .q(cnt_reg)
    );

    assign match_cnt = cnt_reg;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pd_stream.sv
// Directed bench for pd_stream (PW=4, bit 0 examined) against a behavioural
// word memory with combinational read.
module tb_pd_stream;

    localparam int DW = 10;
    localparam int AW = 10;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] data;
    logic [PW-1:0] pattern = 4'b1010;
    logic          ovl = 1'b1;
    logic [AW-1:0] addr;
    logic          flag;
    logic          fin;
    logic [AW-1:0] match_cnt;

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    int total = 0;
    int bad   = 0;
    int cnt_on;

    assign data = mem[addr];

    always #5 clk = ~clk;

    pd_stream #(.DW(DW), .AW(AW), .PW(PW), .BIT_SEL(0)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .pattern(pattern), .ovl(ovl),
        .addr(addr), .flag(flag), .fin(fin), .match_cnt(match_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits[i] is the examined bit of word i; other data bits carry noise.
    task automatic load(input logic [15:0] bits, input logic [AW-1:0] len);
        for (int i = 0; i < (1 << AW); i++) mem[i] = 10'h2A6;
        for (int i = 0; i < 16; i++) mem[i] = 10'h2A6 | {9'd0, bits[i]};
        mem[(1 << AW) - 1] = len;
    endtask

    task automatic reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_addr"}, addr, 10'h3FF);
        chk({tag, "_rst_fin"}, fin, 0);
        chk({tag, "_rst_flag"}, flag, 0);
        chk({tag, "_rst_cnt"}, match_cnt, 0);
    endtask

    // Called at a negedge with reset asserted; releases it and runs to fin.
    task automatic scan(input string tag, input logic [15:0] exp_seen,
                        input int exp_fin_edge, input int exp_cnt,
                        input logic [AW-1:0] exp_addr, input int chg_at);
        logic [15:0] seen;
        int e;
        seen = '0;
        e = 0;
        rst_n = 1'b1;
        while (!fin && e < 40) begin
            if (flag && addr < 16) seen[addr[3:0]] = 1'b1;
            if (chg_at >= 0 && int'(addr) == chg_at && e > 0) pattern = 4'b0000;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        if (!fin) chk({tag, "_fin_timeout"}, 0, 1);
        chk({tag, "_flags"}, seen, exp_seen);
        chk({tag, "_fin_edge"}, e, exp_fin_edge);
        chk({tag, "_cnt"}, match_cnt, exp_cnt * cnt_on);
        chk({tag, "_addr"}, addr, exp_addr);
        repeat (3) @(negedge clk);
        chk({tag, "_hold_fin"}, fin, 1);
        chk({tag, "_hold_addr"}, addr, exp_addr);
        chk({tag, "_hold_flag"}, flag, 0);
        $display("scenario %s: flags=%04h fin_edge=%0d cnt=%0d addr=%0d",
                 tag, seen, e, match_cnt, addr);
    endtask

    initial begin
`ifdef PD_MATCH_CNT_EN
        cnt_on = 1;
`else
        cnt_on = 0;
`endif
        // Overlapping: 1,0,1,0,1,0,0 matches 1010 ending at words 3 and 5.
        load(16'h0015, 10'd6);
        pattern = 4'b1010;
        ovl = 1'b1;
        @(negedge clk);
        reset_check("ovl1");
        @(negedge clk);
        scan("ovl1", 16'h0028, 8, 2, 10'd6, -1);

        // Non-overlapping: history refill after word 3 suppresses word 5.
        ovl = 1'b0;
        @(negedge clk);
        reset_check("ovl0");
        @(negedge clk);
        scan("ovl0", 16'h0008, 8, 1, 10'd6, -1);

        // All-ones length word skips the scan entirely.
        load(16'h0015, 10'h3FF);
        ovl = 1'b1;
        @(negedge clk);
        reset_check("len3ff");
        @(negedge clk);
        scan("len3ff", 16'h0000, 1, 0, 10'd0, -1);

        // Single word scanned; history never fills so no match possible.
        load(16'h0001, 10'd0);
        @(negedge clk);
        reset_check("len0");
        @(negedge clk);
        scan("len0", 16'h0000, 2, 0, 10'd0, -1);

        // Reset while sitting on a matching word, then a clean full rerun.
        load(16'h0015, 10'd6);
        @(negedge clk);
        reset_check("mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && addr != 10'd3; i++) @(negedge clk);
        chk("mid_reach3", addr, 10'd3);
        chk("mid_flag3", flag, 1);
        reset_check("mid_abort");
        @(negedge clk);
        scan("mid_rerun", 16'h0028, 8, 2, 10'd6, -1);

        // Pattern input changes mid-scan; the INIT-latched 1010 still applies.
        pattern = 4'b1010;
        @(negedge clk);
        reset_check("patchg");
        @(negedge clk);
        scan("patchg", 16'h0028, 8, 2, 10'd6, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
